bos_packet_router: RTL and testbench
====================================

// Module: bos_packet_router
// PURPOSE
//  Host-link packet router between the byte-wide host transceiver (UART/SPI bridge) and the
//  per-address register/slave blocks. Rx path: parses SYNC/ADDR/LEN/payload packets and
//  drives master_data plus a one-hot valid_bus strobe per payload byte.
//  Tx path: round-robin arbitrates slaves' have_msg_bus, pops slave bytes via rdreq_bus,
//  and frames them as SYNC/ADDR/LEN/payload packets back to the host.
// PARAMETERS
//  N_SLAVES  10      number of addressable slaves (valid/rdreq/have_msg width)
//  SYNC      8'h55   packet start byte (both directions)
//  TIMEOUT   50000   rx inter-byte timeout in clk cycles; 16-bit counter
// PORTS
//  clk             in   1           system clock
//  n_rst           in   1           asynchronous reset, active-low
//  rx_data         in   8           byte from host transceiver
//  rx_valid        in   1           rx_data valid, 1-cycle pulse per byte
//  tx_data         out  8           byte to host transceiver
//  tx_valid        out  1           tx_data valid; held until tx_ready
//  tx_ready        in   1           transceiver accepts byte when tx_valid&tx_ready
//  master_data     out  8           payload byte to slaves
//  valid_bus       out  N_SLAVES    one-hot write strobe, bit = ADDR
//  rdreq_bus       out  N_SLAVES    one-hot pop strobe to slave show-ahead FIFO
//  have_msg_bus    in   N_SLAVES    slave i has a message pending
//  slave_data_bus  in   8*N_SLAVES  slave i current byte at [8i+7:8i], show-ahead
//  len_bus         in   8*N_SLAVES  slave i message length at [8i+7:8i]
//  err_addr        out  1           1-cycle pulse: rx ADDR >= N_SLAVES
// BEHAVIOUR
//  Reset: all FSMs idle; master_data=0, valid_bus=0, rdreq_bus=0, tx_data=0, tx_valid=0,
//   err_addr=0, rr pointer=N_SLAVES-1, counters 0. Reset mid-packet aborts both directions.
//  Rx FSM R_IDLE->R_ADDR->R_LEN->R_DATA->R_IDLE, advances only on rx_valid:
//   R_IDLE: byte==SYNC -> R_ADDR; other bytes dropped.
//   R_ADDR: latch addr; addr>=N_SLAVES -> err_addr pulse next cycle, packet still parsed
//    but no strobes. R_LEN: latch cnt; cnt==0 -> R_IDLE, else R_DATA.
//   R_DATA: each byte -> next cycle master_data=byte, valid_bus[addr]=1 one cycle
//    (latency 1); cnt-- ; cnt reaching 0 -> R_IDLE. master_data holds last value otherwise.
//   Timeout: counter clears on rx_valid, counts in non-idle states; reaching TIMEOUT-1
//    -> R_IDLE, no strobe. A SYNC value inside ADDR/LEN/DATA is data, not a resync.
//  Tx FSM T_IDLE->T_SYNC->T_ADDR->T_LEN->T_DATA->T_IDLE:
//   T_IDLE: if any have_msg, pick first set bit searching rr+1, rr+2, ... wrapping;
//    latch idx, len=len_bus[idx]; rr<=idx; go T_SYNC with tx_valid=1, tx_data=SYNC.
//   T_SYNC/T_ADDR/T_LEN: on tx_valid&tx_ready load next byte (idx zero-extended, len);
//    at T_LEN handshake with len==0 -> T_IDLE, tx_valid=0.
//   T_DATA: tx_data=slave_data_bus[idx] (mux, not registered), tx_valid=1;
//    rdreq_bus[idx]=tx_valid&tx_ready (combinational, one cycle per byte); cnt--;
//    last byte -> T_IDLE. have_msg deassertion mid-message is ignored; len honoured.
//   tx_valid/tx_data stable while tx_ready=0. At least one T_IDLE cycle between packets.
//  Rx and Tx independent; simultaneous rx byte and tx handshake both serviced same cycle.
//  Width: cnt 8-bit, max payload 255; addr 8-bit compared against N_SLAVES.
// STRUCTURE
//  Shared package bos_pkg: SYNC byte constant, rx/tx state enums, N_SLAVES default.
//  One sub-module: bos_rr_arbiter (N_SLAVES req, rr pointer -> one-hot grant + index).
//  Rx parser and Tx framer stay as two always blocks in this module.
// TESTING
//  55 03 02 A1 B2 -> valid_bus=10'h008 on 2 cycles, master_data A1 then B2; err_addr=0.
//  55 0C 01 FF -> err_addr pulse, valid_bus stays 0, next 55 00 00 parsed cleanly.
//  55 01 05 11 then TIMEOUT idle cycles -> R_IDLE; next 55 02 01 7E -> valid_bus[2], 7E.
//  have_msg[4], len 2, bytes C3,D4, tx_ready=1 -> tx 55 04 02 C3 D4; rdreq[4] 2 pulses.
//  have_msg[1]&[7] held, rr=1 -> slave 7 served, then slave 1; tx_ready toggled
//   randomly -> tx_data stable while tx_valid&!tx_ready, no duplicated rdreq.
//  n_rst low during T_DATA and R_DATA -> all outputs 0, FSMs idle, next packets OK.

Source files
------------

// File: rtl/bos_pkg.sv
// Shared definitions for the host-link packet router.
//   SYNC_BYTE    : packet start marker used in both directions
//   N_SLAVES_DEF : default number of addressable slaves
//   rx_state_t   : receive parser states
//   tx_state_t   : transmit framer states
//   idx_width()  : width of a slave index for a given slave count
package bos_pkg;

    localparam int         N_SLAVES_DEF = 10;
    localparam logic [7:0] SYNC_BYTE    = 8'h55;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_LEN,
        R_DATA
    } rx_state_t;

    typedef enum logic [2:0] {
        T_IDLE,
        T_SYNC,
        T_ADDR,
        T_LEN,
        T_DATA
    } tx_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bos_rr_arbiter.sv
// Round-robin arbiter for the transmit path.
// Picks the first requesting slave after rr_ptr, wrapping around.
//   req       in   N_SLAVES  per-slave request (have_msg)
//   rr_ptr    in   IDX_W     index of the most recently served slave
//   grant     out  N_SLAVES  one-hot grant (zero when no request)
//   grant_idx out  IDX_W     binary index of the granted slave
//   grant_vld out  1         at least one request present
module bos_rr_arbiter
    import bos_pkg::*;
#(
    parameter int N_SLAVES = N_SLAVES_DEF,
    parameter int IDX_W    = idx_width(N_SLAVES)
) (
    input  logic [N_SLAVES-1:0] req,
    input  logic [IDX_W-1:0]    rr_ptr,
    output logic [N_SLAVES-1:0] grant,
    output logic [IDX_W-1:0]    grant_idx,
    output logic                grant_vld
);

    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;
    logic             hi_found;

    // Lowest requester above the pointer wins; otherwise wrap to the
    // lowest requester overall. Scanning downward leaves the lowest hit.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IDX_W'(i);
            end
            if (req[i] && (i > int'(rr_ptr))) begin
                hi_idx   = IDX_W'(i);
                hi_found = 1'b1;
            end
        end
    end

    assign grant_idx = hi_found ? hi_idx : lo_idx;
    assign grant_vld = |req;

    always_comb begin
        grant = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            grant[i] = grant_vld && (grant_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/bos_packet_router.sv
// Host-link packet router.
// Rx: parses SYNC/ADDR/LEN/payload from the host and strobes each payload
//     byte to the addressed slave (master_data + one-hot valid_bus).
// Tx: round-robin selects a slave with a pending message and frames it as
//     SYNC/ADDR/LEN/payload back to the host, popping slave bytes via rdreq_bus.
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   rx_data, rx_valid     byte stream from host (1-cycle pulse per byte)
//   tx_data, tx_valid     byte stream to host, held until tx_ready
//   tx_ready              host accepts byte when tx_valid & tx_ready
//   master_data           payload byte to slaves
//   valid_bus             one-hot write strobe, bit = packet ADDR
//   rdreq_bus             one-hot pop strobe to slave show-ahead FIFOs
//   have_msg_bus          per-slave message pending
//   slave_data_bus        per-slave head byte, slave i at [8i+7:8i]
//   len_bus               per-slave message length, slave i at [8i+7:8i]
//   err_addr              1-cycle pulse when a received ADDR is out of range
module bos_packet_router
    import bos_pkg::*;
#(
    parameter int         N_SLAVES = N_SLAVES_DEF,
    parameter logic [7:0] SYNC     = SYNC_BYTE,
    parameter int         TIMEOUT  = 50000
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [7:0]            master_data,
    output logic [N_SLAVES-1:0]   valid_bus,
    output logic [N_SLAVES-1:0]   rdreq_bus,
    input  logic [N_SLAVES-1:0]   have_msg_bus,
    input  logic [8*N_SLAVES-1:0] slave_data_bus,
    input  logic [8*N_SLAVES-1:0] len_bus,
    output logic                  err_addr
);

    localparam int          IDX_W    = idx_width(N_SLAVES);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Rx parser state
    // ------------------------------------------------------------------
    rx_state_t             r_state;
    logic [7:0]            r_addr;
    logic                  r_addr_ok;
    logic [7:0]            r_cnt;
    logic [15:0]           r_tmo;
    logic [N_SLAVES-1:0]   addr_onehot;

    always_comb begin
        addr_onehot = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            addr_onehot[i] = (r_addr == 8'(i));
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= R_IDLE;
            r_addr      <= '0;
            r_addr_ok   <= 1'b0;
            r_cnt       <= '0;
            r_tmo       <= '0;
            master_data <= '0;
            valid_bus   <= '0;
            err_addr    <= 1'b0;
        end else begin
            valid_bus <= '0;
            err_addr  <= 1'b0;
            if (rx_valid) begin
                r_tmo <= '0;
                case (r_state)
                    R_IDLE: begin
                        if (rx_data == SYNC) begin
                            r_state <= R_ADDR;
                        end
                    end
                    R_ADDR: begin
                        // Out-of-range packets are still parsed to stay in
                        // frame, but never produce write strobes.
                        r_addr    <= rx_data;
                        r_addr_ok <= ({1'b0, rx_data} < 9'(N_SLAVES));
                        err_addr  <= ({1'b0, rx_data} >= 9'(N_SLAVES));
                        r_state   <= R_LEN;
                    end
                    R_LEN: begin
                        r_cnt   <= rx_data;
                        r_state <= (rx_data == 8'd0) ? R_IDLE : R_DATA;
                    end
                    R_DATA: begin
                        master_data <= rx_data;
                        if (r_addr_ok) begin
                            valid_bus <= addr_onehot;
                        end
                        r_cnt <= r_cnt - 8'd1;
                        if (r_cnt == 8'd1) begin
                            r_state <= R_IDLE;
                        end
                    end
                    default: r_state <= R_IDLE;
                endcase
            end else if (r_state != R_IDLE) begin
                // Inter-byte gap too long: abandon the partial packet.
                if (r_tmo == TMO_LAST) begin
                    r_state <= R_IDLE;
                    r_tmo   <= '0;
                end else begin
                    r_tmo <= r_tmo + 16'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Tx framer
    // ------------------------------------------------------------------
    tx_state_t             t_state;
    logic [IDX_W-1:0]      t_idx;
    logic [N_SLAVES-1:0]   t_grant;
    logic [7:0]            t_len;
    logic [7:0]            tx_hdr;
    logic [IDX_W-1:0]      rr_ptr;
    logic [N_SLAVES-1:0]   arb_grant;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_vld;
    logic                  tx_fire;
    logic [7:0]            len_arr   [N_SLAVES];
    logic [7:0]            sbyte_arr [N_SLAVES];

    always_comb begin
        for (int i = 0; i < N_SLAVES; i++) begin
            len_arr[i]   = len_bus[8*i +: 8];
            sbyte_arr[i] = slave_data_bus[8*i +: 8];
        end
    end

    bos_rr_arbiter #(
        .N_SLAVES (N_SLAVES),
        .IDX_W    (IDX_W)
    ) u_arb (
        .req       (have_msg_bus),
        .rr_ptr    (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    assign tx_fire = tx_valid && tx_ready;

    // Payload bytes come straight from the slave's show-ahead head, so the
    // pop strobe must be combinational with the handshake.
    assign tx_data   = (t_state == T_DATA) ? sbyte_arr[t_idx] : tx_hdr;
    assign rdreq_bus = ((t_state == T_DATA) && tx_fire) ? t_grant : '0;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            t_state  <= T_IDLE;
            t_idx    <= '0;
            t_grant  <= '0;
            t_len    <= '0;
            tx_hdr   <= '0;
            tx_valid <= 1'b0;
            rr_ptr   <= IDX_W'(N_SLAVES - 1);
        end else begin
            case (t_state)
                T_IDLE: begin
                    if (arb_vld) begin
                        t_idx    <= arb_idx;
                        t_grant  <= arb_grant;
                        t_len    <= len_arr[arb_idx];
                        rr_ptr   <= arb_idx;
                        tx_hdr   <= SYNC;
                        tx_valid <= 1'b1;
                        t_state  <= T_SYNC;
                    end
                end
                T_SYNC: begin
                    if (tx_fire) begin
                        tx_hdr  <= 8'(t_idx);
                        t_state <= T_ADDR;
                    end
                end
                T_ADDR: begin
                    if (tx_fire) begin
                        tx_hdr  <= t_len;
                        t_state <= T_LEN;
                    end
                end
                T_LEN: begin
                    if (tx_fire) begin
                        if (t_len == 8'd0) begin
                            tx_valid <= 1'b0;
                            t_state  <= T_IDLE;
                        end else begin
                            t_state <= T_DATA;
                        end
                    end
                end
                T_DATA: begin
                    // Length latched at grant is authoritative; have_msg is
                    // not re-examined until the next idle cycle.
                    if (tx_fire) begin
                        t_len <= t_len - 8'd1;
                        if (t_len == 8'd1) begin
                            tx_valid <= 1'b0;
                            t_state  <= T_IDLE;
                        end
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    t_state  <= T_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bos_packet_router.sv
`timescale 1ns/1ps
module tb_bos_packet_router;

    localparam int N   = 10;
    localparam int TMO = 64;

    logic           clk = 1'b0;
    logic           n_rst = 1'b0;
    logic [7:0]     rx_data = 8'h00;
    logic           rx_valid = 1'b0;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready = 1'b1;
    logic [7:0]     master_data;
    logic [N-1:0]   valid_bus;
    logic [N-1:0]   rdreq_bus;
    logic [N-1:0]   have_msg_bus = '0;
    logic [8*N-1:0] slave_data_bus = '0;
    logic [8*N-1:0] len_bus = '0;
    logic           err_addr;

    always #5 clk = ~clk;

    bos_packet_router #(.N_SLAVES(N), .SYNC(8'h55), .TIMEOUT(TMO)) dut (
        .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .master_data(master_data), .valid_bus(valid_bus), .rdreq_bus(rdreq_bus),
        .have_msg_bus(have_msg_bus), .slave_data_bus(slave_data_bus),
        .len_bus(len_bus), .err_addr(err_addr)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [N-1:0] vb; logic [7:0] md; } rx_exp_t;
    typedef struct packed { logic [7:0] b; logic [N-1:0] rd; } tx_exp_t;
    rx_exp_t rx_q[$];
    tx_exp_t tx_q[$];
    int      err_exp = 0;

    // Slave-side model: per-slave byte FIFO and message-length FIFO
    logic [7:0]   sb[N][$];
    int           sl[N][$];
    int           sused[N];
    logic [N-1:0] pop_pend = '0;
    bit           rand_ready = 1'b0;
    int           model_rr = N - 1;

    logic [7:0] rx_pl[$];
    int         tx_slv[$];
    int         tx_len[$];
    logic [7:0] tx_fix[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] slave_oh(input int a);
        logic [N-1:0] v;
        v = '0;
        if (a >= 0 && a < N) v[a] = 1'b1;
        return v;
    endfunction

    task automatic refresh_slaves();
        for (int i = 0; i < N; i++) begin
            have_msg_bus[i]          = (sl[i].size() > 0);
            len_bus[8*i +: 8]        = (sl[i].size() > 0) ? 8'(sl[i][0]) : 8'h00;
            slave_data_bus[8*i +: 8] = (sb[i].size() > 0) ? sb[i][0] : 8'h00;
        end
    endtask

    // Capture pops while rdreq is stable, apply them just after the edge
    always @(negedge clk) pop_pend = rdreq_bus;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (pop_pend[i]) begin
                    if (sb[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rdreq_empty: got pop on slave %0d, expected none", i);
                    end else begin
                        void'(sb[i].pop_front());
                        sused[i]++;
                        if (sused[i] == sl[i][0]) begin
                            void'(sl[i].pop_front());
                            sused[i] = 0;
                        end
                    end
                end
            end
            pop_pend = '0;
            refresh_slaves();
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Rx monitor
    always @(negedge clk) begin
        if (n_rst) begin
            if (valid_bus != '0) begin
                if (rx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got valid_bus %0h, expected none", valid_bus);
                end else begin
                    rx_exp_t e;
                    e = rx_q.pop_front();
                    check("rx_valid_bus", 32'(valid_bus), 32'(e.vb));
                    check("rx_master_data", 32'(master_data), 32'(e.md));
                end
            end
            if (err_addr) begin
                checks++;
                if (err_exp == 0) begin
                    errors++;
                    $display("FAIL err_addr_unexpected: got 1 expected 0");
                end else begin
                    err_exp--;
                end
            end
        end
    end

    // Tx monitor
    bit         stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;
    always @(negedge clk) begin
        if (!n_rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("tx_hold_valid", 32'(tx_valid), 32'd1);
                check("tx_hold_data", 32'(tx_data), 32'(stall_data));
            end
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got %0h, expected none", tx_data);
                end else begin
                    tx_exp_t e;
                    e = tx_q.pop_front();
                    check("tx_data", 32'(tx_data), 32'(e.b));
                    check("tx_rdreq", 32'(rdreq_bus), 32'(e.rd));
                end
            end else begin
                check("rdreq_idle", 32'(rdreq_bus), 32'd0);
            end
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
        end
    end

    // Caller is aligned 1 time unit after a rising edge
    task automatic rx_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rx_packet(input int addr, input int maxgap);
        if (addr >= N) begin
            err_exp++;
        end else begin
            foreach (rx_pl[k]) rx_q.push_back('{vb: slave_oh(addr), md: rx_pl[k]});
        end
        rx_byte(8'h55, $urandom_range(0, maxgap));
        rx_byte(8'(addr), $urandom_range(0, maxgap));
        rx_byte(8'(rx_pl.size()), $urandom_range(0, maxgap));
        foreach (rx_pl[k]) rx_byte(rx_pl[k], $urandom_range(0, maxgap));
    endtask

    // Loads messages into the slaves in one step and predicts the framed
    // output: each message is served by the first pending slave after the
    // previously served one, wrapping around.
    task automatic tx_batch();
        int         mine[N][$];
        int         off[$];
        logic [7:0] flat[$];
        int         remaining;
        @(negedge clk);
        #1;
        foreach (tx_slv[k]) begin
            off.push_back(flat.size());
            for (int j = 0; j < tx_len[k]; j++) begin
                logic [7:0] b;
                b = (flat.size() < tx_fix.size()) ? tx_fix[flat.size()] : 8'($urandom_range(0, 255));
                flat.push_back(b);
                sb[tx_slv[k]].push_back(b);
            end
            sl[tx_slv[k]].push_back(tx_len[k]);
            mine[tx_slv[k]].push_back(k);
        end
        remaining = tx_slv.size();
        while (remaining > 0) begin
            int pick;
            int k;
            pick = -1;
            for (int d = 1; d <= N; d++) begin
                int s;
                s = (model_rr + d) % N;
                if (pick < 0 && mine[s].size() > 0) pick = s;
            end
            k = mine[pick].pop_front();
            tx_q.push_back('{b: 8'h55, rd: '0});
            tx_q.push_back('{b: 8'(pick), rd: '0});
            tx_q.push_back('{b: 8'(tx_len[k]), rd: '0});
            for (int j = 0; j < tx_len[k]; j++) tx_q.push_back('{b: flat[off[k] + j], rd: slave_oh(pick)});
            model_rr = pick;
            remaining--;
        end
        refresh_slaves();
    endtask

    task automatic wait_tx();
        int n;
        n = 0;
        while (tx_q.size() > 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (tx_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL tx_drain: got %0d bytes outstanding, expected 0", tx_q.size());
            tx_q.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic drain_all(input string tag);
        int n;
        n = 0;
        while ((tx_q.size() > 0 || rx_q.size() > 0 || err_exp > 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tx_q.size() > 0 || rx_q.size() > 0 || err_exp != 0) begin
            errors++;
            $display("FAIL drain_%s: got tx=%0d rx=%0d err=%0d outstanding, expected 0", tag,
                     tx_q.size(), rx_q.size(), err_exp);
            tx_q.delete();
            rx_q.delete();
            err_exp = 0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_master_data"}, 32'(master_data), 32'd0);
        check({tag, "_valid_bus"}, 32'(valid_bus), 32'd0);
        check({tag, "_rdreq_bus"}, 32'(rdreq_bus), 32'd0);
        check({tag, "_err_addr"}, 32'(err_addr), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < N; i++) sused[i] = 0;
        refresh_slaves();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // Directed traffic, rx and tx concurrently
        fork
            begin
                rx_pl = {8'hA1, 8'hB2};
                rx_packet(3, 0);
                rx_byte(8'h13, 1);
                rx_byte(8'hAA, 0);
                rx_pl = {8'hFF};
                rx_packet(12, 0);
                rx_pl = {};
                rx_packet(0, 0);
                rx_pl = {8'h55};
                rx_packet(6, 2);
                // partial packet, then silence long enough to time out
                rx_q.push_back('{vb: slave_oh(1), md: 8'h11});
                rx_byte(8'h55, 0);
                rx_byte(8'h01, 0);
                rx_byte(8'h05, 0);
                rx_byte(8'h11, TMO + 4);
                rx_pl = {8'h7E};
                rx_packet(2, 0);
            end
            begin
                rand_ready = 1'b0;
                tx_slv = {4}; tx_len = {2}; tx_fix = {8'hC3, 8'hD4};
                tx_batch();
                wait_tx();
                tx_slv = {1}; tx_len = {1}; tx_fix = {};
                tx_batch();
                wait_tx();
                rand_ready = 1'b1;
                tx_slv = {1, 7}; tx_len = {3, 2};
                tx_batch();
                wait_tx();
            end
        join
        drain_all("directed");

        // Randomized traffic
        fork
            begin
                for (int p = 0; p < 30; p++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        logic [7:0] g;
                        g = 8'($urandom_range(0, 255));
                        if (g == 8'h55) g = 8'hAA;
                        rx_byte(g, $urandom_range(0, 2));
                    end
                    rx_pl = {};
                    for (int j = 0, n = $urandom_range(0, 5); j < n; j++)
                        rx_pl.push_back(($urandom_range(0, 3) == 0) ? 8'h55 : 8'($urandom_range(0, 255)));
                    rx_packet($urandom_range(0, 12), 3);
                end
            end
            begin
                rand_ready = 1'b1;
                for (int b = 0; b < 8; b++) begin
                    tx_slv = {}; tx_len = {}; tx_fix = {};
                    for (int m = 0, n = $urandom_range(1, 5); m < n; m++) begin
                        tx_slv.push_back($urandom_range(0, N - 1));
                        tx_len.push_back($urandom_range(1, 6));
                    end
                    tx_batch();
                    wait_tx();
                end
            end
        join
        drain_all("random");

        // Reset in the middle of R_DATA and T_DATA
        rand_ready = 1'b0;
        tx_slv = {5}; tx_len = {20}; tx_fix = {};
        tx_batch();
        @(posedge clk);
        #1;
        rx_q.push_back('{vb: slave_oh(2), md: 8'h01});
        rx_q.push_back('{vb: slave_oh(2), md: 8'h02});
        rx_byte(8'h55, 0);
        rx_byte(8'h02, 0);
        rx_byte(8'h0A, 0);
        rx_byte(8'h01, 0);
        rx_byte(8'h02, 2);
        @(negedge clk);
        #1;
        n_rst = 1'b0;
        tx_q.delete();
        rx_q.delete();
        err_exp = 0;
        for (int i = 0; i < N; i++) begin
            sb[i].delete();
            sl[i].delete();
            sused[i] = 0;
        end
        pop_pend = '0;
        model_rr = N - 1;
        refresh_slaves();
        #2;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        fork
            begin
                rx_pl = {8'h7E};
                rx_packet(2, 0);
                rx_pl = {8'h21, 8'h22, 8'h23};
                rx_packet(9, 1);
            end
            begin
                rand_ready = 1'b1;
                tx_slv = {3, 8}; tx_len = {3, 1};
                tx_batch();
                wait_tx();
            end
        join
        drain_all("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
